// File: rtl/pipe_stb_pkg.sv
// Shared types and helpers for the pipeline store buffer.
`timescale 1ns/1ps
package pipe_stb_pkg;

  localparam int STB_DEPTH = 4;
  localparam int STB_AW    = 32;
  localparam int STB_DW    = 32;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } stb_state_t;

  typedef struct packed {
    logic              valid;
    logic [STB_AW-1:0] addr;
    logic [STB_DW-1:0] data;
  } stb_entry_t;

  // Word-granular match key: byte offset bits are shifted out.
  function automatic logic [STB_AW-1:0] word_key(input logic [STB_AW-1:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/stb_fifo.sv
// Circular store storage with head/tail/count and a per-entry view for address matching.
`timescale 1ns/1ps
module stb_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [PW-1:0] head_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic [DEPTH-1:0] valid_vec,
  output logic [AW-1:0] addr_vec [DEPTH],
  output logic [DW-1:0] data_vec [DEPTH]
);

  logic [PW-1:0]    head_reg, tail_reg;
  logic [CW-1:0]    count_reg;
  logic [DEPTH-1:0] valid_reg, valid_next;
  logic [AW-1:0]    addr_mem [DEPTH];
  logic [DW-1:0]    data_mem [DEPTH];

  // Push is applied after pop so a full push+pop reuses the retiring slot.
  always_comb begin
    valid_next = valid_reg;
    if (pop)  valid_next[head_reg] = 1'b0;
    if (push) valid_next[tail_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      valid_reg <= '0;
    end else begin
      if (pop)  head_reg <= head_reg + PW'(1);
      if (push) tail_reg <= tail_reg + PW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
      valid_reg <= valid_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_reg] <= push_addr;
      data_mem[tail_reg] <= push_data;
    end
  end

  assign head_addr = addr_mem[head_reg];
  assign head_data = data_mem[head_reg];
  assign head_ptr  = head_reg;
  assign count     = count_reg;
  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign valid_vec = valid_reg;
  assign addr_vec  = addr_mem;
  assign data_vec  = data_mem;

endmodule

// File: rtl/pipe_store_buffer.sv
// Store buffer between the MEM stage and single-port data memory: posts stores, retires them
// in idle port cycles, forwards to loads and drains on flush. Build option: STB_FWD_EN.
`timescale 1ns/1ps
module pipe_store_buffer
  import pipe_stb_pkg::*;
#(
  parameter int DEPTH = STB_DEPTH,
  parameter int AW    = STB_AW,
  parameter int DW    = STB_DW
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          m_wmem,
  input  logic          m_rmem,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_data,
  output logic [DW-1:0] m_rdata,
  output logic          m_stall,
  input  logic          flush_req,
  output logic          flush_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_datain,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dataout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  stb_state_t state_reg, state_next;
  logic       flush_done_reg, flush_done_next;

  logic          push, pop;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic [PW-1:0] head_ptr;
  logic [CW-1:0] count, count_next;
  logic          full, empty;
  logic [DEPTH-1:0] valid_vec, hit_vec;
  logic [AW-1:0] addr_vec [DEPTH];
  logic [DW-1:0] data_vec [DEPTH];

  logic          load_req, load_hold, load_port, flush_stall, hit;
  logic [PW-1:0] scan_idx;
  logic [DW-1:0] fwd_data;

  stb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk       (clk),
    .clrn      (clrn),
    .push      (push),
    .pop       (pop),
    .push_addr (m_addr),
    .push_data (m_data),
    .head_addr (head_addr),
    .head_data (head_data),
    .head_ptr  (head_ptr),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .valid_vec (valid_vec),
    .addr_vec  (addr_vec),
    .data_vec  (data_vec)
  );

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign hit_vec[gi] = valid_vec[gi] &&
                         (word_key(STB_AW'(addr_vec[gi])) == word_key(STB_AW'(m_addr)));
  end

  assign hit = |hit_vec;

  // Walk oldest to youngest so the last matching entry wins.
  always_comb begin
    fwd_data = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_ptr + PW'(k);
      if (hit_vec[scan_idx]) fwd_data = data_vec[scan_idx];
    end
  end

  assign load_req = m_rmem && !m_wmem;

`ifdef STB_FWD_EN
  assign load_hold = 1'b0;
`else
  assign load_hold = load_req && hit;
`endif

  assign flush_stall = (state_reg == FLUSH) || (flush_req && !empty);
  assign m_stall     = flush_stall || load_hold;

  // A load keeps the port unless a store arrives on a full buffer, which needs the drain slot.
  assign load_port  = m_rmem && !m_stall && !(m_wmem && full);
  assign pop        = !load_port && !empty;
  assign push       = m_wmem && !m_stall;
  assign count_next = count + CW'(push) - CW'(pop);

  assign mem_we     = pop;
  assign mem_addr   = pop ? head_addr : m_addr;
  assign mem_datain = head_data;

  // A hazard-stalled load has don't-care data, so one mux serves both build options.
  assign m_rdata = (load_req && hit) ? fwd_data : mem_dataout;

  always_comb begin
    state_next      = state_reg;
    flush_done_next = 1'b0;
    case (state_reg)
      RUN: begin
        if (flush_req) begin
          if (count_next == '0) flush_done_next = 1'b1;
          else                  state_next      = FLUSH;
        end
      end
      FLUSH: begin
        if (count_next == '0) begin
          state_next      = RUN;
          flush_done_next = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg      <= RUN;
      flush_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      flush_done_reg <= flush_done_next;
    end
  end

  assign flush_done = flush_done_reg;

endmodule
